// File: rtl/if_pc_unit_if.sv
// Bus between the instruction-fetch PC unit and the surrounding pipeline stages.
// Optional macro IF_PC_MISALIGN_EN adds the instr_misaligned_o flag.
interface if_pc_unit_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instruction_id_i;
    logic            branch_condition_i;
    logic [XLEN-1:0] branch_adder_id_i;
    logic [XLEN-1:0] alu_result_ex_i;
    logic            stall_i;
    logic [XLEN-1:0] pc_next_if_o;
    logic [XLEN-1:0] pc_reg_if_o;
    logic [XLEN-1:0] pc_reg_id_o;
    logic            if_id_flush_o;
    logic            id_ex_flush_o;
    logic            jalr_ex_o;
`ifdef IF_PC_MISALIGN_EN
    logic            instr_misaligned_o;
`endif

    // The pipeline side drives decode/hazard information and consumes the PCs.
    modport master (
`ifdef IF_PC_MISALIGN_EN
        input  instr_misaligned_o,
`endif
        output instruction_id_i,
        output branch_condition_i,
        output branch_adder_id_i,
        output alu_result_ex_i,
        output stall_i,
        input  pc_next_if_o,
        input  pc_reg_if_o,
        input  pc_reg_id_o,
        input  if_id_flush_o,
        input  id_ex_flush_o,
        input  jalr_ex_o
    );

    modport slave (
`ifdef IF_PC_MISALIGN_EN
        output instr_misaligned_o,
`endif
        input  instruction_id_i,
        input  branch_condition_i,
        input  branch_adder_id_i,
        input  alu_result_ex_i,
        input  stall_i,
        output pc_next_if_o,
        output pc_reg_if_o,
        output pc_reg_id_o,
        output if_id_flush_o,
        output id_ex_flush_o,
        output jalr_ex_o
    );
endinterface

// File: rtl/if_pc_unit.sv
// Instruction-fetch PC generator: next-PC selection, IF/ID PC register and JALR tracking.
// Optional macro IF_PC_MISALIGN_EN: misaligned-target flag and forced 4-byte alignment of redirects.
module if_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset,
    if_pc_unit_if.slave  bus
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] JALR_EX = 1'b1;

    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_reg_if_q, pc_reg_if_d;
    logic [XLEN-1:0] pc_reg_id_q, pc_reg_id_d;
    logic [0:0]      state_q, state_d;

    logic            isJalr, isJal, isBr, brTaken;
    logic            jalrEx;
    logic            redirect;
    logic [XLEN-1:0] redirectTarget;
    logic            ifIdFlush, idExFlush;
    logic            unused_instr_bits;

    assign isJalr  = (bus.instruction_id_i[6:0] == OPC_JALR);
    assign isJal   = (bus.instruction_id_i[6:0] == OPC_JAL);
    assign isBr    = (bus.instruction_id_i[6:0] == OPC_BR);
    // funct3[0] distinguishes the inverted comparisons (BNE/BGE/BGEU).
    assign brTaken = isBr && (bus.instruction_id_i[12] ^ bus.branch_condition_i);
    assign jalrEx  = (state_q == JALR_EX);

    assign unused_instr_bits = ^{bus.instruction_id_i[31:13], bus.instruction_id_i[11:7]};

    always_comb begin
        redirect       = 1'b0;
        redirectTarget = bus.branch_adder_id_i;
        pc_reg_if_d    = pc_reg_if_q + PC_STEP;
        if (jalrEx) begin
            redirect       = 1'b1;
            redirectTarget = bus.alu_result_ex_i;
        end else if (bus.stall_i) begin
            pc_reg_if_d    = pc_reg_if_q;
        end else if (isJal || brTaken) begin
            redirect       = 1'b1;
            redirectTarget = bus.branch_adder_id_i;
        end
        if (redirect) begin
`ifdef IF_PC_MISALIGN_EN
            pc_reg_if_d = {redirectTarget[XLEN-1:2], 2'b00};
`else
            pc_reg_if_d = redirectTarget;
`endif
        end
    end

    assign ifIdFlush = jalrEx | (!bus.stall_i & (isJal | brTaken));
    assign idExFlush = jalrEx | bus.stall_i;

    // A JALR redirects only if it actually enters EX, i.e. it was not bubbled.
    always_comb begin
        state_d     = (isJalr && !idExFlush) ? JALR_EX : IDLE;
        pc_reg_id_d = (!bus.stall_i || jalrEx) ? pc_reg_if_q : pc_reg_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg_if_q <= RESET_PC;
            pc_reg_id_q <= '0;
            state_q     <= IDLE;
        end else begin
            pc_reg_if_q <= pc_reg_if_d;
            pc_reg_id_q <= pc_reg_id_d;
            state_q     <= state_d;
        end
    end

`ifdef IF_PC_MISALIGN_EN
    logic misaligned_q, misaligned_d;

    assign misaligned_d = redirect && (redirectTarget[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.instr_misaligned_o = misaligned_q;
`endif

    assign bus.pc_next_if_o  = pc_reg_if_d;
    assign bus.pc_reg_if_o   = pc_reg_if_q;
    assign bus.pc_reg_id_o   = pc_reg_id_q;
    assign bus.if_id_flush_o = ifIdFlush;
    assign bus.id_ex_flush_o = idExFlush;
    assign bus.jalr_ex_o     = jalrEx;

endmodule

// File: doc/if_pc_unit.md
Name: if_pc_unit

Overview:
- Instruction-fetch PC generator for the RV32IMA pipeline; produces pc_next_if, the fetch PC, and the IF/ID PC register.
- Selects among sequential PC+4, the ID-stage branch/JAL target (branch_adder_id), and the EX-stage JALR target (alu_result_ex).
- Tracks JALR from ID into EX and issues the IF/ID and ID/EX flushes that squash wrong-path instructions.
- Sits directly upstream of the ID-stage branch logic and consumes its results.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- XLEN, 32, width of PC and target buses.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- instruction_id_i  in  32  instruction currently in ID.
- branch_condition_i  in  1  comparator result for the B-type instruction in ID.
- branch_adder_id_i  in  XLEN  pc_reg_id + immediate; the JAL/branch target.
- alu_result_ex_i  in  XLEN  ALU output in EX; the JALR target.
- stall_i  in  1  load-use stall from the hazard unit.
- pc_next_if_o  out  XLEN  next fetch address (combinational).
- pc_reg_if_o  out  XLEN  current fetch address.
- pc_reg_id_o  out  XLEN  PC of the instruction in ID.
- if_id_flush_o  out  1  squash the IF/ID register.
- id_ex_flush_o  out  1  insert a bubble into ID/EX.
- jalr_ex_o  out  1  a valid JALR is in EX.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: pc_reg_if=RESET_PC, pc_reg_id=0, jalr_ex=0. The flush outputs follow combinationally from these values.
- Decode from instruction_id_i[6:0]:
  - JALR = 1100111.
  - JAL = 1101111.
  - BR = 1100011.
  - br_taken = BR && (instruction_id_i[12] ^ branch_condition_i).
- Next-PC priority (combinational), first match wins:
  1. jalr_ex -> alu_result_ex_i.
  2. stall_i -> pc_reg_if (hold).
  3. JAL -> branch_adder_id_i.
  4. br_taken -> branch_adder_id_i.
  5. otherwise pc_reg_if+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- Flushes (combinational):
  - if_id_flush_o = jalr_ex | (!stall_i & (JAL | br_taken)).
  - id_ex_flush_o = jalr_ex | stall_i.
- Registers, updated every clock:
  - pc_reg_if <= pc_next_if_o.
  - pc_reg_id <= pc_reg_if when !stall_i or jalr_ex; otherwise it holds.
  - jalr_ex <= JALR && !id_ex_flush_o.
- JALR state: jalr_ex is a single-bit IDLE/JALR_EX state.
  - A JALR in ID that is not bubbled moves the state to JALR_EX for exactly one cycle.
  - A JALR that is itself bubbled or squashed never redirects.
- JALR redirect latency: one cycle after the JALR leaves ID. A redirect costs 2 bubbles.
- JAL/branch redirect latency: 0 cycles (same-cycle pc_next). A redirect costs 1 bubble.
- Simultaneous events:
  - A JALR in EX overrides JAL/branch in ID and overrides stall. The ID instruction is wrong-path and is flushed, not executed.
  - A stall suppresses ID redirects; the branch re-evaluates on the next unstalled cycle.
- Reset mid-operation: every register returns to its reset value on the next edge. A pending jalr_ex is discarded.

Optional Feature:
- Macro: IF_PC_MISALIGN_EN.
- With the macro defined:
  - Adds output instr_misaligned_o (1 bit, reset 0, registered).
  - It pulses high one cycle after a selected redirect target (JALR, JAL or taken branch) has bits [1:0] != 0.
  - pc_next_if_o bits [1:0] are forced to 0 for every redirect.
- Without the macro: the port is absent and redirect targets pass unmodified.

Test Plan:
- Reset with RESET_PC=32'h100, no branches for 3 cycles -> pc_reg_if 0x100, 0x104, 0x108, 0x10C; all flushes 0.
- JAL in ID with branch_adder_id_i=0x200 -> same cycle pc_next_if_o=0x200, if_id_flush_o=1; next cycle pc_reg_if=0x200.
- BEQ in ID (bit12=0):
  - branch_condition_i=1, target 0x300 -> pc_next=0x300 and if_id_flush.
  - branch_condition_i=0 -> pc_next=pc+4, no flush.
  - BNE (bit12=1) with branch_condition_i=0 -> taken.
- JALR in ID, then JAL in ID next cycle with alu_result_ex_i=0x400 and branch_adder 0x500 -> jalr_ex_o=1, pc_next=0x400, both flushes=1.
- stall_i=1 with a taken branch in ID -> pc held, id_ex_flush_o=1, if_id_flush_o=0; when stall_i drops -> redirect taken.
- pc_reg_if=32'hFFFF_FFFC, no branch -> next pc 0. Reset asserted while jalr_ex=1 -> next cycle jalr_ex_o=0, pc_reg_if=RESET_PC.
